dsp_2int8_unpack_acc: RTL and testbench

//   Receive-side companion of the dual-int8 DSP multiplier.
//   - Input: one raw packed product per beat, P = (a*2^SHIFT + d) * b.
//   - Splits P into the two signed int8xint8 products, ab and db, applying the borrow correction.
//   - Accumulates each product stream over a vector framed by in_last.
//   - Returns one pair of sums per vector over a valid/ready output.
//   - Sits between the DSP packer output and the dot-product / requant logic.
//

---
 rtl/dsp_2int8_unpack_acc_if.sv | 44 ++++
 rtl/dsp_2int8_unpack_acc.sv | 148 ++++++++++++++
 tb/tb_dsp_2int8_unpack_acc.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_2int8_unpack_acc_if.sv
// dsp_2int8_unpack_acc_if: packed-product input stream and
// per-vector accumulated result stream, both valid/ready.
interface dsp_2int8_unpack_acc_if #(
  parameter int PROD_W = 36,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_p;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc_ab;
  logic [ACC_W-1:0]  out_acc_db;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  modport master (
    output in_valid,
    output in_p,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc_ab,
    input  out_acc_db,
    input  out_count,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_p,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc_ab,
    output out_acc_db,
    output out_count,
    output out_sat
  );
endinterface

// File: rtl/dsp_2int8_unpack_acc.sv
// dsp_2int8_unpack_acc: splits dual-int8 DSP products into ab/db
// and accumulates both streams over in_last-framed vectors.
module dsp_2int8_unpack_acc #(
  parameter int PROD_W = 36,
  parameter int SHIFT  = 18,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst_n,
  dsp_2int8_unpack_acc_if.slave bus
);
  localparam int PW = 16;
  localparam int HW = PROD_W - SHIFT;
  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic [PW-1:0] ab;
    logic [PW-1:0] db;
    logic          last;
  } s1_t;

  logic             rdy_en;
  logic             s1_valid;
  s1_t              s1_q;
  s1_t              s1_d;
  logic             in_ready;
  logic             accept;
  logic             consume;
  logic             stall;
  logic [HW:0]      ab_w;

  logic [ACC_W-1:0] acc_ab;
  logic [ACC_W-1:0] acc_db;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [ACC_W:0]   add_ab;
  logic [ACC_W:0]   add_db;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  logic             out_valid;
  logic [ACC_W-1:0] res_ab;
  logic [ACC_W-1:0] res_db;
  logic [CNT_W-1:0] res_cnt;
  logic             res_sat;

  function automatic logic [ACC_W:0] sat_add(
    input logic [ACC_W-1:0] acc,
    input logic [PW-1:0]    x
  );
    logic [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc}
        + {{(ACC_W+1-PW){x[PW-1]}}, x};
    if (sum[ACC_W] != sum[ACC_W-1])
      return {1'b1, sum[ACC_W] ? ACC_MIN : ACC_MAX};
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  // A negative low field borrowed one from the upper field.
  assign ab_w =
    {bus.in_p[PROD_W-1], bus.in_p[PROD_W-1:SHIFT]}
    + {{HW{1'b0}}, bus.in_p[SHIFT-1]};

  always_comb begin
    s1_d      = '0;
    s1_d.ab   = ab_w[PW-1:0];
    s1_d.db   = bus.in_p[PW-1:0];
    s1_d.last = bus.in_last;
  end

  assign stall = s1_valid && s1_q.last
              && out_valid && !bus.out_ready;
  assign in_ready = rdy_en && (!s1_valid || !stall);
  assign accept   = bus.in_valid && in_ready;
  assign consume  = s1_valid && !stall;

  always_comb begin
    add_ab  = sat_add(acc_ab, s1_q.ab);
    add_db  = sat_add(acc_db, s1_q.db);
    cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
    sat_nxt = sat || add_ab[ACC_W] || add_db[ACC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (consume) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_ab  <= '0;
      acc_db  <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
      res_ab  <= '0;
      res_db  <= '0;
      res_cnt <= '0;
      res_sat <= 1'b0;
    end else if (consume) begin
      if (s1_q.last) begin
        res_ab  <= add_ab[ACC_W-1:0];
        res_db  <= add_db[ACC_W-1:0];
        res_cnt <= cnt_nxt;
        res_sat <= sat_nxt;
        acc_ab  <= '0;
        acc_db  <= '0;
        cnt     <= '0;
        sat     <= 1'b0;
      end else begin
        acc_ab <= add_ab[ACC_W-1:0];
        acc_db <= add_db[ACC_W-1:0];
        cnt    <= cnt_nxt;
        sat    <= sat_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_valid <= 1'b0;
    else if (consume && s1_q.last)
      out_valid <= 1'b1;
    else if (out_valid && bus.out_ready)
      out_valid <= 1'b0;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_acc_ab = res_ab;
  assign bus.out_acc_db = res_db;
  assign bus.out_count  = res_cnt;
  assign bus.out_sat    = res_sat;
endmodule

// File: tb/tb_dsp_2int8_unpack_acc.sv
// tb_dsp_2int8_unpack_acc: random and directed stimulus on a
// 24-bit and a 16-bit accumulator instance fed the same stream.
module tb_dsp_2int8_unpack_acc;
  typedef struct packed {
    logic signed [31:0] ab24;
    logic signed [31:0] db24;
    logic signed [31:0] ab16;
    logic signed [31:0] db16;
    logic [31:0]        cnt;
    logic               sat24;
    logic               sat16;
    logic               v16;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  int   m_ab24, m_db24, m_ab16, m_db16, m_cnt;
  bit   m_sat24, m_sat16;
  res_t expq[$];

  always #5 clk = ~clk;

  dsp_2int8_unpack_acc_if #(
    .PROD_W(36), .ACC_W(24), .CNT_W(8)) bus ();
  dsp_2int8_unpack_acc_if #(
    .PROD_W(36), .ACC_W(16), .CNT_W(8)) bus16 ();

  assign bus16.in_valid  = bus.in_valid;
  assign bus16.in_p      = bus.in_p;
  assign bus16.in_last   = bus.in_last;
  assign bus16.out_ready = bus.out_ready;

  dsp_2int8_unpack_acc #(
    .PROD_W(36), .SHIFT(18), .ACC_W(24), .CNT_W(8)
  ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  dsp_2int8_unpack_acc #(
    .PROD_W(36), .SHIFT(18), .ACC_W(16), .CNT_W(8)
  ) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  function automatic string fmt(input res_t r);
    return $sformatf(
      "ab=%0d db=%0d cnt=%0d sat=%0b ab16=%0d db16=%0d sat16=%0b v16=%0b",
      r.ab24, r.db24, r.cnt, r.sat24,
      r.ab16, r.db16, r.sat16, r.v16);
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  function automatic int clampw(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic add_sat(inout int acc, input int x,
                         input int w, inout bit s);
    int t;
    t = acc + x;
    if (clampw(t, w) != t) s = 1'b1;
    acc = clampw(t, w);
  endtask

  task automatic model_clear();
    m_ab24 = 0; m_db24 = 0; m_ab16 = 0; m_db16 = 0;
    m_cnt = 0; m_sat24 = 0; m_sat16 = 0;
  endtask

  task automatic model_beat(input int a, d, b, input bit last);
    res_t e;
    add_sat(m_ab24, a * b, 24, m_sat24);
    add_sat(m_db24, d * b, 24, m_sat24);
    add_sat(m_ab16, a * b, 16, m_sat16);
    add_sat(m_db16, d * b, 16, m_sat16);
    if (m_cnt < 255) m_cnt++;
    if (last) begin
      e.ab24 = m_ab24; e.db24 = m_db24;
      e.ab16 = m_ab16; e.db16 = m_db16;
      e.cnt = m_cnt; e.sat24 = m_sat24;
      e.sat16 = m_sat16; e.v16 = 1'b1;
      expq.push_back(e);
      model_clear();
    end
  endtask

  task automatic sample(output res_t o);
    o.ab24  = {{8{bus.out_acc_ab[23]}}, bus.out_acc_ab};
    o.db24  = {{8{bus.out_acc_db[23]}}, bus.out_acc_db};
    o.ab16  = {{16{bus16.out_acc_ab[15]}}, bus16.out_acc_ab};
    o.db16  = {{16{bus16.out_acc_db[15]}}, bus16.out_acc_db};
    o.cnt   = {24'b0, bus.out_count};
    o.sat24 = bus.out_sat;
    o.sat16 = bus16.out_sat;
    o.v16   = bus16.out_valid;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input int a, d, b, input bit last);
    longint p;
    bit     done;
    done = 1'b0;
    p = (longint'(a) * 262144 + longint'(d)) * longint'(b);
    bus.in_p     = p[35:0];
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (done) @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (done) begin
      model_beat(a, d, b, last);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=%b want 1",
               bus.in_ready);
    end
  endtask

  task automatic get_result(output res_t o, output bit ok);
    ok = 1'b0;
    o  = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.out_valid === 1'b1) begin
        sample(o);
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    res_t o;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.in_p = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sample(o);
    checks++;
    if (o !== '0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got %s v=%b want all 0",
               fmt(o), bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus16.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b/%b want 0",
               bus.in_ready, bus16.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b/%b want 1",
               bus.in_ready, bus16.in_ready);
    end
  endtask

  task automatic test_unpack();
    res_t o, e;
    bit   ok;
    send_beat(-128, -1, 1, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_latency_n1 got %b want 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL t1_latency_n2 got %b want 1", bus.out_valid);
    end
    get_result(o, ok);
    e = expq.pop_front();
    checks++;
    if (!ok || o.ab24 !== -32'sd128 || o.db24 !== -32'sd1
        || o.cnt !== 32'd1 || o.sat24 !== 1'b0) begin
      errors++;
      $display("FAIL t1_unpack got %s want ab=-128 db=-1 cnt=1 sat=0",
               fmt(o));
    end
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL t1_model got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_borrow();
    int   vals[4];
    int   bs[3];
    res_t o, e;
    bit   ok;
    vals = '{-128, -1, 0, 127};
    bs   = '{-128, 1, 127};
    foreach (vals[i]) foreach (vals[j]) foreach (bs[k]) begin
      send_beat(vals[i], vals[j], bs[k], 1'b1);
      get_result(o, ok);
      e = expq.pop_front();
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL t2_a%0d_d%0d_b%0d got %s want %s",
                 vals[i], vals[j], bs[k], fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_dot();
    res_t o, e;
    bit   ok;
    send_beat(100, 100, 100, 1'b0);
    for (int i = 0; i < 3; i++)
      send_beat(-50, 20, 3, i == 2);
    get_result(o, ok);
    e = expq.pop_front();
    checks++;
    if (!ok || o.ab24 !== 32'sd9550 || o.db24 !== 32'sd10180
        || o.cnt !== 32'd4) begin
      errors++;
      $display("FAIL t3_dot got %s want ab=9550 db=10180 cnt=4",
               fmt(o));
    end
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL t3_model got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_random();
    res_t o, e;
    bit   ok;
    int   len;
    for (int v = 0; v < 20; v++) begin
      len = int'($urandom_range(8, 1));
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(2)) @(negedge clk);
        send_beat(rnd8(), rnd8(), rnd8(), k == len - 1);
      end
      get_result(o, ok);
      e = expq.pop_front();
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL rand_vec%0d got %s want %s",
                 v, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_backpressure();
    res_t o, e;
    bit   ok;
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 3; k++)
        send_beat(rnd8(), rnd8(), rnd8(), k == 2);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL t4_stall_c%0d got in_ready=%b want 0",
                 c, bus.in_ready);
      end
      sample(o);
      e = expq[0];
      checks++;
      if (bus.out_valid !== 1'b1 || o !== e) begin
        errors++;
        $display("FAIL t4_hold_c%0d got v=%b %s want v=1 %s",
                 c, bus.out_valid, fmt(o), fmt(e));
      end
      @(negedge clk);
    end
    for (int v = 0; v < 2; v++) begin
      get_result(o, ok);
      e = expq.pop_front();
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL t4_deliver%0d got %s want %s",
                 v, fmt(o), fmt(e));
      end
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t4_drain got rdy=%b v=%b want rdy=1 v=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_saturation();
    res_t o, e;
    bit   ok;
    for (int k = 0; k < 3; k++)
      send_beat(127, rnd8(), 127, k == 2);
    get_result(o, ok);
    e = expq.pop_front();
    checks++;
    if (!ok || o.ab16 !== 32'sd32767 || o.sat16 !== 1'b1
        || o !== e) begin
      errors++;
      $display("FAIL t5_sat got %s want %s", fmt(o), fmt(e));
    end
    send_beat(rnd8(), rnd8(), rnd8(), 1'b1);
    get_result(o, ok);
    e = expq.pop_front();
    checks++;
    if (!ok || o.sat16 !== 1'b0 || o !== e) begin
      errors++;
      $display("FAIL t5_next got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_count_sat();
    res_t o, e;
    bit   ok;
    for (int k = 0; k < 520; k++)
      send_beat(-128, 127, -128, k == 519);
    get_result(o, ok);
    e = expq.pop_front();
    checks++;
    if (!ok || o.cnt !== 32'd255 || o.sat24 !== 1'b1
        || o !== e) begin
      errors++;
      $display("FAIL long_vec got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int v = 0; v < 10; v++) begin
          send_beat(rnd8(), rnd8(), rnd8(), 1'b1);
          if ($urandom_range(1) == 1)
            send_beat(rnd8(), rnd8(), rnd8(), 1'b1);
        end
      end
      begin
        res_t o, e;
        bit   ok;
        int   n;
        n = 0;
        while (n < 10 || expq.size() > 0) begin
          get_result(o, ok);
          if (!ok) break;
          e = expq.pop_front();
          checks++;
          if (o !== e) begin
            errors++;
            $display("FAIL b2b_%0d got %s want %s",
                     n, fmt(o), fmt(e));
          end
          n++;
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    res_t o, e;
    bit   ok;
    send_beat(rnd8(), rnd8(), rnd8(), 1'b0);
    send_beat(rnd8(), rnd8(), rnd8(), 1'b0);
    rst_n = 1'b0;
    #1;
    sample(o);
    checks++;
    if (o !== '0 || bus.out_valid !== 1'b0
        || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL t6_reset got %s v=%b rdy=%b want 0",
               fmt(o), bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    expq.delete();
    @(negedge clk);
    send_beat(rnd8(), rnd8(), rnd8(), 1'b1);
    get_result(o, ok);
    e = expq.pop_front();
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL t6_after got %s want %s", fmt(o), fmt(e));
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    @(negedge clk);
    test_unpack();
    test_borrow();
    test_dot();
    test_random();
    test_backpressure();
    test_saturation();
    test_count_sat();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
